cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 EXC_VECTOR, 32'h0000_4180, PC redirect target for syscall and interrupt entry.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 CP0WE / CP0WAddr / CP0WData  input  1/5/32  MTC0 write strobe, register number, data.
REQ-005 CP0RE / CP0RAddr  input  1/5  MFC0 read strobe, register number.
REQ-006 CP0RData  output  32  MFC0 read data.
REQ-007 ExcSyscall / ExcEret  input  1/1  exception strobes from the decoder, valid for the current decoded instruction.
REQ-008 PC  input  32  address of the instruction currently in decode.
REQ-009 HWInt  input  6  level-sensitive external interrupt lines.
REQ-010 ExcTaken  output  1  pipeline flush and redirect request, combinational.
REQ-011 ExcTarget  output  32  redirect PC, valid while ExcTaken=1.

Function
REQ-012 Registers implemented: Count(9), Compare(11), Status(12), Cause(13), EPC(14); any other address reads 0; writes to other addresses are ignored.
REQ-013 Status bit layout: IM = bits 15:8, EXL = bit 1, IE = bit 0; only these bits are writable; all other bits read 0.
REQ-014 Cause bit layout: IP7..IP2 = bits 15:10 (hardware, read-only), IP1..IP0 = bits 9:8 (writable), ExcCode = bits 6:2 (hardware only); all other bits read 0.
REQ-015 Cause.IP6..IP2 shall be registered from HWInt[4:0] every cycle, giving 1-cycle latency.
REQ-016 Interrupt pending condition: IntReq = IE & ~EXL & |(Cause[15:8] & Status[15:8]).
REQ-017 Entry priority: IntReq > ExcSyscall > ExcEret.
REQ-018 Interrupt entry: ExcTaken=1, ExcTarget=EXC_VECTOR; at the edge, EPC<=PC, ExcCode<=0, EXL<=1.
REQ-019 Syscall entry: ExcTaken=1, ExcTarget=EXC_VECTOR; at the edge, EPC<=PC, ExcCode<=8, EXL<=1.
REQ-020 ERET (no higher-priority event): ExcTaken=1, ExcTarget=EPC current value; at the edge, EXL<=0.
REQ-021 Exception entry or ERET in the same cycle as an MTC0 to Status, Cause or EPC: the hardware update wins for the bits it owns (EPC, ExcCode, EXL); other written bits still take the written value.
REQ-022 CP0RData is combinational: CP0RE=0 gives 0; otherwise the addressed register value.
REQ-023 Read bypass: if CP0WE=1 and CP0WAddr==CP0RAddr, CP0RData shall return the masked CP0WData.
REQ-024 Without timer, Cause.IP7 is registered from HWInt[5].

Reset
REQ-025 On rst_n=0, independent of clk: Status, Cause, EPC, Count and Compare shall be 0, and IP bits cleared.
REQ-026 While rst_n=0, ExcTaken=0 and CP0RData=0.
REQ-027 Leaving reset needs no clock alignment; the first active edge after deassertion performs normal updates.

Configuration
REQ-028 Macro CP0_TIMER_EN selects the Count/Compare timer.
REQ-029 With CP0_TIMER_EN defined, Count shall increment by 1 every cycle and wrap 32'hFFFF_FFFF to 0.
REQ-030 With CP0_TIMER_EN defined, an MTC0 to Count shall load the written value instead of incrementing.
REQ-031 With CP0_TIMER_EN defined, Cause.IP7 shall be set when Count==Compare and stay set until an MTC0 to Compare clears it (the write wins over a same-cycle match).
REQ-032 With CP0_TIMER_EN defined, HWInt[5] shall be ignored.
REQ-033 Without CP0_TIMER_EN, Count and Compare read 0, writes to them are ignored, and IP7 follows REQ-024.

Verification
REQ-034 Reset, then MTC0 Status=32'hFFFF_FFFF, then MFC0 Status -> 32'h0000_FF03.
REQ-035 PC=32'h0000_3010 with ExcSyscall=1 -> ExcTaken=1 and ExcTarget=32'h0000_4180 in that cycle; next cycle EPC=32'h0000_3010, Cause[6:2]=8, EXL=1.
REQ-036 After REQ-035, ExcEret=1 -> ExcTarget=32'h0000_3010; next cycle EXL=0.
REQ-037 Status=32'h0000_0401, HWInt=6'b000001 -> ExcTaken=1 on the second cycle, with ExcCode=0; the same stimulus with EXL=1 -> no ExcTaken.
REQ-038 (CP0_TIMER_EN) Compare=20, Count=15, Status=32'h0000_8001 -> IP7 set after 5 cycles and interrupt taken; MTC0 Compare clears IP7.
REQ-039 Same-cycle MTC0 EPC=32'h1234 with ExcSyscall at PC=32'h40 -> EPC=32'h40; assert rst_n=0 mid-operation -> all registers 0 immediately.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 block: Status/Cause/EPC plus optional Count/Compare timer, MTC0/MFC0 access,
// syscall/interrupt entry and ERET redirect. Timer enabled by defining CP0_TIMER_EN.
module cp0_unit #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CP0WE,
  input  logic [4:0]        CP0WAddr,
  input  logic [DATA_W-1:0] CP0WData,
  input  logic              CP0RE,
  input  logic [4:0]        CP0RAddr,
  output logic [DATA_W-1:0] CP0RData,
  input  logic              ExcSyscall,
  input  logic              ExcEret,
  input  logic [DATA_W-1:0] PC,
  input  logic [5:0]        HWInt,
  output logic              ExcTaken,
  output logic [DATA_W-1:0] ExcTarget
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] EXC_INT   = 5'd0;
  localparam logic [4:0] EXC_SYS   = 5'd8;

  logic [7:0]        im;
  logic              exl;
  logic              ie;
  logic [5:0]        ip_hw;
  logic [1:0]        ip_sw;
  logic [4:0]        exc_code;
  logic [DATA_W-1:0] epc;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] cause_word;
  logic              int_req;
  logic              entry;
  logic              wr_status;
  logic              wr_cause;
  logic              wr_epc;
  logic              bypass;
  logic [DATA_W-1:0] rdata_raw;

`ifdef CP0_TIMER_EN
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] compare;
  logic              wr_count;
  logic              wr_compare;
`endif

  // Software-writable bits of each register; used both for MTC0 and the read bypass.
  function automatic logic [DATA_W-1:0] wr_mask(input logic [4:0] a);
    case (a)
      A_STATUS: wr_mask = DATA_W'(32'h0000_FF03);
      A_CAUSE:  wr_mask = DATA_W'(32'h0000_0300);
      A_EPC:    wr_mask = '1;
`ifdef CP0_TIMER_EN
      A_COUNT:   wr_mask = '1;
      A_COMPARE: wr_mask = '1;
`endif
      default:  wr_mask = '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] reg_word(input logic [4:0] a);
    case (a)
      A_STATUS: reg_word = status_word;
      A_CAUSE:  reg_word = cause_word;
      A_EPC:    reg_word = epc;
`ifdef CP0_TIMER_EN
      A_COUNT:   reg_word = count;
      A_COMPARE: reg_word = compare;
`endif
      default:  reg_word = '0;
    endcase
  endfunction

  assign status_word = DATA_W'({16'h0, im, 6'h0, exl, ie});
  assign cause_word  = DATA_W'({16'h0, ip_hw, ip_sw, 1'b0, exc_code, 2'b00});

  assign wr_status = CP0WE && (CP0WAddr == A_STATUS);
  assign wr_cause  = CP0WE && (CP0WAddr == A_CAUSE);
  assign wr_epc    = CP0WE && (CP0WAddr == A_EPC);

  // Interrupt outranks syscall, both outrank ERET.
  assign int_req   = ie && !exl && (|({ip_hw, ip_sw} & im));
  assign entry     = int_req || ExcSyscall;
  assign ExcTaken  = rst_n && (entry || ExcEret);
  assign ExcTarget = entry ? EXC_VECTOR : epc;

  assign bypass    = CP0WE && (CP0WAddr == CP0RAddr);
  assign rdata_raw = bypass ? (CP0WData & wr_mask(CP0WAddr)) : reg_word(CP0RAddr);
  assign CP0RData  = (rst_n && CP0RE) ? rdata_raw : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (wr_status) begin
        im  <= CP0WData[15:8];
        exl <= CP0WData[1];
        ie  <= CP0WData[0];
      end
      if (entry)        exl <= 1'b1;
      else if (ExcEret) exl <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_sw    <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      if (wr_cause) ip_sw <= CP0WData[9:8];
      if (entry) begin
        exc_code <= int_req ? EXC_INT : EXC_SYS;
        epc      <= PC;
      end else if (wr_epc) begin
        epc <= CP0WData;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ip_hw[4:0] <= '0;
    else        ip_hw[4:0] <= HWInt[4:0];
  end

`ifdef CP0_TIMER_EN
  assign wr_count   = CP0WE && (CP0WAddr == A_COUNT);
  assign wr_compare = CP0WE && (CP0WAddr == A_COMPARE);

  // IP7 latches a timer match and holds it until software rewrites Compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      compare  <= '0;
      ip_hw[5] <= 1'b0;
    end else begin
      count <= wr_count ? CP0WData : count + 1'b1;
      if (wr_compare) compare <= CP0WData;
      if (wr_compare)            ip_hw[5] <= 1'b0;
      else if (count == compare) ip_hw[5] <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ip_hw[5] <= 1'b0;
    else        ip_hw[5] <= HWInt[5];
  end
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: directed scenarios plus random traffic against a word-level model.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CP0WE;
  logic [4:0]  CP0WAddr;
  logic [31:0] CP0WData;
  logic        CP0RE;
  logic [4:0]  CP0RAddr;
  logic [31:0] CP0RData;
  logic        ExcSyscall;
  logic        ExcEret;
  logic [31:0] PC;
  logic [5:0]  HWInt;
  logic        ExcTaken;
  logic [31:0] ExcTarget;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk(clk), .rst_n(rst_n),
    .CP0WE(CP0WE), .CP0WAddr(CP0WAddr), .CP0WData(CP0WData),
    .CP0RE(CP0RE), .CP0RAddr(CP0RAddr), .CP0RData(CP0RData),
    .ExcSyscall(ExcSyscall), .ExcEret(ExcEret), .PC(PC), .HWInt(HWInt),
    .ExcTaken(ExcTaken), .ExcTarget(ExcTarget)
  );

  localparam logic [31:0] VEC = 32'h0000_4180;

  typedef struct {
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] rd;
  } exp_t;

  exp_t  expq[$];
  string nameq[$];
  int    checks = 0;
  int    errors = 0;

  // Architectural model: whole 32-bit register words.
  logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [4:0] a);
    case (a)
      5'd12: return 32'h0000_FF03;
      5'd13: return 32'h0000_0300;
      5'd14: return 32'hFFFF_FFFF;
`ifdef CP0_TIMER_EN
      5'd9, 5'd11: return 32'hFFFF_FFFF;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] reg_of(input logic [4:0] a);
    case (a)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_intreq();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  // Apply one cycle of inputs and queue the outputs the model predicts for it.
  task automatic drive(input string nm, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra, input logic sys, input logic er,
                       input logic [31:0] pc, input logic [5:0] hw);
    exp_t e;
    logic ir;
    CP0WE = we; CP0WAddr = wa; CP0WData = wd; CP0RE = re; CP0RAddr = ra;
    ExcSyscall = sys; ExcEret = er; PC = pc; HWInt = hw;
    if (!rst_n) begin
      m_status = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0;
    end
    ir    = m_intreq();
    e.tk  = rst_n && (ir || sys || er);
    e.tgt = (ir || sys) ? VEC : m_epc;
    if (!rst_n || !re)      e.rd = 32'h0;
    else if (we && wa == ra) e.rd = wd & mask_of(wa);
    else                     e.rd = reg_of(ra);
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic tick();
    logic [31:0] ns, nc, ne, ncnt, ncmp;
    logic ir;
    ir = m_intreq();
    ns = m_status; nc = m_cause; ne = m_epc; ncnt = m_count; ncmp = m_compare;
    if (CP0WE) begin
      case (CP0WAddr)
        5'd12: ns = CP0WData & 32'h0000_FF03;
        5'd13: nc = (nc & ~32'h0000_0300) | (CP0WData & 32'h0000_0300);
        5'd14: ne = CP0WData;
`ifdef CP0_TIMER_EN
        5'd11: ncmp = CP0WData;
`endif
        default: ;
      endcase
    end
`ifdef CP0_TIMER_EN
    ncnt = (CP0WE && CP0WAddr == 5'd9) ? CP0WData : m_count + 32'd1;
    if (CP0WE && CP0WAddr == 5'd11) nc[15] = 1'b0;
    else if (m_count == m_compare)  nc[15] = 1'b1;
`else
    nc[15] = HWInt[5];
`endif
    nc[14:10] = HWInt[4:0];
    if (ir || ExcSyscall) begin
      ne = PC;
      nc[6:2] = ir ? 5'd0 : 5'd8;
      ns[1] = 1'b1;
    end else if (ExcEret) begin
      ns[1] = 1'b0;
    end
    if (!rst_n) begin
      ns = 0; nc = 0; ne = 0; ncnt = 0; ncmp = 0;
    end
    @(posedge clk);
    m_status = ns; m_cause = nc; m_epc = ne; m_count = ncnt; m_compare = ncmp;
    #1;
  endtask

  task automatic idle(input logic [5:0] hw);
    drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, hw);
    tick();
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [5:0] hw);
    drive(nm, 0, 0, 0, 1, a, 0, 0, 0, hw);
  endtask

  task automatic wr(input string nm, input logic [4:0] a, input logic [31:0] d, input logic [5:0] hw);
    drive(nm, 1, a, d, 0, 0, 0, 0, 0, hw);
    tick();
  endtask

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 5'd9;
      1: return 5'd11;
      2: return 5'd12;
      3: return 5'd13;
      4: return 5'd14;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // Monitor: every cycle the DUT presents combinational outputs; compare against the queue head.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n = nameq.pop_front();
      check32({n, ".taken"}, {31'h0, ExcTaken}, {31'h0, e.tk});
      if (e.tk) check32({n, ".target"}, ExcTarget, e.tgt);
      check32({n, ".rdata"}, CP0RData, e.rd);
    end
  end

  initial begin
    logic        seen;
    logic [5:0]  hw;
    rst_n = 1'b0;
    CP0WE = 0; CP0WAddr = 0; CP0WData = 0; CP0RE = 0; CP0RAddr = 0;
    ExcSyscall = 0; ExcEret = 0; PC = 0; HWInt = 0;
    m_status = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0;
    @(posedge clk); #1;

    // Held in reset: outputs silent despite active strobes.
    drive("reset_hold", 1, 5'd12, 32'hFFFF_FFFF, 1, 5'd12, 1, 0, 32'h100, 6'h3F);
    #1;
    check32("reset_taken", {31'h0, ExcTaken}, 32'h0);
    check32("reset_rdata", CP0RData, 32'h0);
    tick();
    drive("reset_hold2", 0, 0, 0, 1, 5'd13, 0, 1, 0, 6'h3F);
    tick();
    rst_n = 1'b1;

`ifdef CP0_TIMER_EN
    wr("cmp_park", 5'd11, 32'hFFFF_0000, 6'h0);
`endif

    // Status write mask and read bypass.
    drive("status_wr", 1, 5'd12, 32'hFFFF_FFFF, 1, 5'd12, 0, 0, 0, 6'h0);
    #1 check32("status_bypass", CP0RData, 32'h0000_FF03);
    tick();
    rd("status_rd", 5'd12, 6'h0);
    #1 check32("status_masked", CP0RData, 32'h0000_FF03);
    tick();

    // Syscall entry then ERET.
    drive("syscall", 0, 0, 0, 0, 0, 1, 0, 32'h0000_3010, 6'h0);
    #1 check32("sys_taken", {31'h0, ExcTaken}, 32'h1);
    check32("sys_target", ExcTarget, VEC);
    tick();
    rd("sys_epc", 5'd14, 6'h0);
    #1 check32("sys_epc_val", CP0RData, 32'h0000_3010);
    tick();
    rd("sys_cause", 5'd13, 6'h0);
    #1 check32("sys_exccode", {27'h0, CP0RData[6:2]}, 32'd8);
    tick();
    rd("sys_status", 5'd12, 6'h0);
    #1 check32("sys_exl", {31'h0, CP0RData[1]}, 32'h1);
    tick();
    drive("eret", 0, 0, 0, 0, 0, 0, 1, 32'h0000_5000, 6'h0);
    #1 check32("eret_target", ExcTarget, 32'h0000_3010);
    tick();
    rd("eret_status", 5'd12, 6'h0);
    #1 check32("eret_exl", {31'h0, CP0RData[1]}, 32'h0);
    tick();

    // Hardware EPC update beats a same-cycle MTC0 to EPC.
    drive("epc_race", 1, 5'd14, 32'h0000_1234, 0, 0, 1, 0, 32'h0000_0040, 6'h0);
    tick();
    rd("epc_race_rd", 5'd14, 6'h0);
    #1 check32("epc_race_val", CP0RData, 32'h0000_0040);
    tick();

    // HWInt[0] -> IP2, one cycle of latency, masked by IM2.
    wr("st_int", 5'd12, 32'h0000_0401, 6'h0);
    drive("int_c1", 0, 0, 0, 0, 0, 0, 0, 32'h0000_0200, 6'h01);
    #1 check32("int_c1_taken", {31'h0, ExcTaken}, 32'h0);
    tick();
    drive("int_c2", 0, 0, 0, 0, 0, 0, 0, 32'h0000_0204, 6'h01);
    #1 check32("int_c2_taken", {31'h0, ExcTaken}, 32'h1);
    tick();
    rd("int_cause", 5'd13, 6'h01);
    #1 check32("int_exccode", {27'h0, CP0RData[6:2]}, 32'd0);
    tick();
    wr("st_int_exl", 5'd12, 32'h0000_0403, 6'h0);
    idle(6'h01);
    drive("int_exl_c2", 0, 0, 0, 0, 0, 0, 0, 32'h0000_0300, 6'h01);
    #1 check32("int_exl_blocked", {31'h0, ExcTaken}, 32'h0);
    tick();
    idle(6'h0);

`ifdef CP0_TIMER_EN
    wr("tm_status0", 5'd12, 32'h0, 6'h0);
    wr("tm_compare", 5'd11, 32'd20, 6'h0);
    wr("tm_count", 5'd9, 32'd15, 6'h0);
    wr("tm_status", 5'd12, 32'h0000_8001, 6'h0);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive("tm_wait", 0, 0, 0, 0, 0, 0, 0, 32'h0000_0600, 6'h0);
      #1 seen = ExcTaken;
      tick();
    end
    check32("timer_irq_seen", {31'h0, seen}, 32'h1);
    wr("tm_clear", 5'd11, 32'h1000_0000, 6'h0);
    rd("tm_ip7", 5'd13, 6'h0);
    #1 check32("timer_ip7_clr", {31'h0, CP0RData[15]}, 32'h0);
    tick();
`endif

    // Asynchronous reset mid-operation clears state without a clock edge.
    wr("pre_rst_epc", 5'd14, 32'hDEAD_BEEF, 6'h0);
    rst_n = 1'b0;
    ExcSyscall = 1'b1; CP0RE = 1'b1; CP0RAddr = 5'd14;
    #1 check32("async_rst_taken", {31'h0, ExcTaken}, 32'h0);
    check32("async_rst_rdata", CP0RData, 32'h0);
    rd("async_rst", 5'd14, 6'h0);
    #1 rst_n = 1'b1;
    #1 check32("async_rst_epc", CP0RData, 32'h0);
    tick();
    rd("post_rst_status", 5'd12, 6'h0);
    #1 check32("post_rst_status_val", CP0RData, 32'h0);
    tick();

    // Random traffic against the model.
    hw = 6'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) hw = 6'($urandom);
      drive("rand", ($urandom_range(0, 2) == 0), pick_addr(), $urandom,
            ($urandom_range(0, 3) != 0), pick_addr(),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            $urandom & 32'hFFFF_FFFC, hw);
      tick();
    end
    idle(6'h0);

    for (int i = 0; i < 4 && expq.size() > 0; i++) @(negedge clk);
    #1 check32("drain", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
